slice_add_sequencer: RTL and testbench



---
 rtl/slice_add_pkg.sv | 13 +
 rtl/slice_add4.sv | 29 ++
 rtl/slice_add_sequencer.sv | 133 +++++++++++++
 tb/tb_slice_add_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package slice_add_pkg;

  localparam int SLICE_W    = 4;
  localparam int SLICE_LOG2 = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slice_add4.sv
// Combinational 4-bit ripple-carry adder slice; also reports the carry into
// its top bit so the sequencer can derive signed overflow on the last slice.
module slice_add4
  import slice_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               ci,
  output logic [SLICE_W-1:0] s4,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W:0] c;

  always_comb begin
    s4   = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s4[i]  = a4[i] ^ b4[i] ^ c[i];
      c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
    end
  end

  assign co = c[SLICE_W];
  assign c3 = c[SLICE_W-1];

endmodule

// File: rtl/slice_add_sequencer.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single
// 4-bit adder slice, least-significant nibble first.
module slice_add_sequencer
  import slice_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. start_ready is high only in IDLE; res_valid only in DONE, and
  // it stays high with sum/cout/ovf stable until res_ready is seen.

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BASE_W = IDX_W + SLICE_LOG2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("slice_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]     idx_q;
  logic [BASE_W-1:0]    bit_base;
  logic                 last_slice;
  logic                 capture, step;

  logic [SLICE_W-1:0]   s4;
  logic                 slice_co, slice_c3;

  assign last_slice = (idx_q == LAST_IDX);
  assign bit_base   = BASE_W'(idx_q) << SLICE_LOG2;

  slice_add4 u_slice (
    .a4 (a_q[bit_base +: SLICE_W]),
    .b4 (b_q[bit_base +: SLICE_W]),
    .ci (carry_q),
    .s4 (s4),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_slice)  state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    capture     = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        capture     = start_valid;
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so the inversion happens once at capture
  // and the slice only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (capture) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[bit_base +: SLICE_W] <= s4;
      carry_q                    <= slice_co;
      if (last_slice) begin
        cout_q <= slice_co;
        ovf_q  <= slice_c3 ^ slice_co;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Bench for slice_add_sequencer: directed corner cases plus random add/sub
// traffic scored against an integer-arithmetic model.
module tb_slice_add_sequencer;
  import slice_add_pkg::*;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;
  localparam int W      = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, busy;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int last_accept = 0;
  logic [W-1:0] exp_q[$];

  slice_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // reference model: {cout, ovf, sum} from plain integer arithmetic
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a_i, b_i,
                                         input logic cin_i, sub_i);
    longint ua, ub, sa, sb, full, r, modv, smax, smin, ci;
    logic [WIDTH-1:0] s;
    logic co, ov;
    modv = longint'(1) << WIDTH;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    ua = longint'(a_i);
    ub = longint'(b_i);
    ci = cin_i ? 1 : 0;
    sa = a_i[WIDTH-1] ? ua - modv : ua;
    sb = b_i[WIDTH-1] ? ub - modv : ub;
    if (sub_i) begin
      full = ua - ub - ci;
      co   = (full >= 0);
      r    = sa - sb - ci;
    end else begin
      full = ua + ub + ci;
      co   = (full >= modv);
      r    = sa + sb + ci;
    end
    s  = full[WIDTH-1:0];
    ov = (r > smax) || (r < smin);
    return {co, ov, s};
  endfunction

  // driver tasks (called at a negedge)
  task automatic drive_start(input logic [WIDTH-1:0] a_i, b_i, input logic cin_i, sub_i,
                             output bit ok);
    int t = 0;
    while (!start_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!start_ready) begin
      n_err++;
      ok = 0;
      $display("FAIL start_wait: start_ready=%0b after %0d cycles, required 1", start_ready, t);
      return;
    end
    a = a_i; b = b_i; cin = cin_i; sub = sub_i;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_accept = cycle;
    start_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    ok = 1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a_i, b_i, input logic cin_i, sub_i);
    bit ok;
    int lat = 0;
    exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
    drive_start(a_i, b_i, cin_i, sub_i, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    while (!res_valid && lat < 4 * NSLICE) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== NSLICE) begin
      n_err++;
      $display("FAIL latency: res_valid after %0d edges, required %0d", lat, NSLICE);
    end
  endtask

  task automatic finish_op(input string name, input bit keep_ready);
    logic [W-1:0] got, exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    got = {cout, ovf, sum};
    n_cmp++;
    if (!res_valid || got !== exp) begin
      n_err++;
      $display("FAIL %s result: valid=%0b cout=%0b ovf=%0b sum=%h, required valid=1 cout=%0b ovf=%0b sum=%h",
               name, res_valid, got[W-1], got[W-2], got[WIDTH-1:0], exp[W-1], exp[W-2], exp[WIDTH-1:0]);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep_ready) res_ready = 1'b0;
    n_cmp++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL %s release: start_ready=%0b res_valid=%0b busy=%0b state=%0d, required 1 0 0 %0d",
               name, start_ready, res_valid, busy, state_dbg, IDLE);
    end
    n_cmp++;
    if ({cout, ovf, sum} !== exp) begin
      n_err++;
      $display("FAIL %s retain: {cout,ovf,sum}=%h in idle, required %h", name, {cout, ovf, sum}, exp);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 ||
        cout !== 1'b0 || ovf !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_values: sr=%0b rv=%0b busy=%0b sum=%h cout=%0b ovf=%0b state=%0d, required 1 0 0 0000 0 0 0",
               start_ready, res_valid, busy, sum, cout, ovf, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0); finish_op("plain_add", 1'b0);
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op("carry_ripple", 1'b0);
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op("pos_ovf", 1'b0);
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1); finish_op("sub_borrow", 1'b0);
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); finish_op("add_cin", 1'b0);
    start_op(16'h0000, 16'h0000, 1'b1, 1'b1); finish_op("sub_bin", 1'b0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
    exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({cout, ovf, sum} !== exp || start_ready !== 1'b0 || res_valid !== 1'b1) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: result=%h sr=%0b rv=%0b, required %h 0 1",
                 i, {cout, ovf, sum}, start_ready, res_valid, exp);
      end
    end
    start_valid = 1'b0;
    finish_op("backpressure", 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    drive_start(16'hABCD, 16'h1357, 1'b0, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg !== IDLE || start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      n_err++;
      $display("FAIL reset_mid: state=%0d sr=%0b rv=%0b busy=%0b sum=%h, required 0 1 0 0 0000",
               state_dbg, start_ready, res_valid, busy, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    finish_op("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    int first_accept;
    res_ready = 1'b1;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    first_accept = last_accept;
    finish_op("b2b_first", 1'b1);
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    n_cmp++;
    if (last_accept - first_accept !== NSLICE + 2) begin
      n_err++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart, required %0d",
               last_accept - first_accept, NSLICE + 2);
    end
    finish_op("b2b_second", 1'b0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        default: ra = WIDTH'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
      start_op(ra, rb, 1'($urandom), 1'($urandom));
      finish_op("random", 1'($urandom));
      res_ready = 1'b0;
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
